// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write controller.
// Included by the controller top and its round-robin arbiter.
package regfile_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  typedef enum logic {
    GRANT_CORE,
    GRANT_DBG
  } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; req[0]=core, req[1]=dbg.
// Holds the last winner and advances it only on an accepted transfer.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  grant_e last;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == GRANT_DBG) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= GRANT_DBG;
    end else if (adv) begin
      last <= gnt[1] ? GRANT_DBG : GRANT_CORE;
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port controller: post-reset scrub, then
// round-robin sharing of the single write port between core and debug.
module regfile_write_ctrl
  import regfile_pkg::*;
#(
  parameter int              NREG     = regfile_pkg::NREG,
  parameter int              AW       = regfile_pkg::AW,
  parameter int              DW       = regfile_pkg::DW,
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_valid,
  input  logic [AW-1:0] core_wa,
  input  logic [DW-1:0] core_wd,
  output logic          core_ready,
  input  logic          dbg_valid,
  input  logic [AW-1:0] dbg_wa,
  input  logic [DW-1:0] dbg_wd,
  output logic          dbg_ready,
  input  logic          scrub_req,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          init_done
);

  localparam int IW = $clog2(NREG) + 1;

  state_e        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic          we_n;
  logic [AW-1:0] wa_n;
  logic [DW-1:0] wd_n;
  logic [1:0]    req, gnt;
  logic          run_ok, adv;

  assign req        = {dbg_valid, core_valid};
  assign run_ok     = (state == RUN) && !scrub_req;
  assign core_ready = run_ok && gnt[0];
  assign dbg_ready  = run_ok && gnt[1];
  assign adv        = core_ready || dbg_ready;
  assign init_done  = (state == RUN);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .adv   (adv),
    .gnt   (gnt)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    we_n    = 1'b0;
    wa_n    = rf_wa;
    wd_n    = rf_wd;
    unique case (state)
      INIT: begin
        // idx runs one past the last register so the final scrub
        // write is on the port for a full cycle before RUN.
        if (idx > IW'(NREG - 1)) begin
          state_n = RUN;
        end else begin
          we_n  = 1'b1;
          wa_n  = idx[AW-1:0];
          wd_n  = (idx == '0) ? '0 : INIT_VAL;
          idx_n = idx + 1'b1;
        end
      end
      RUN: begin
        if (scrub_req) begin
          state_n = INIT;
          idx_n   = '0;
        end else if (core_ready) begin
          we_n = |core_wa;
          wa_n = core_wa;
          wd_n = core_wd;
        end else if (dbg_ready) begin
          we_n = |dbg_wa;
          wa_n = dbg_wa;
          wd_n = dbg_wd;
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      idx   <= '0;
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      rf_we <= we_n;
      rf_wa <= wa_n;
      rf_wd <= wd_n;
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Randomized bench for regfile_write_ctrl against a cycle-level
// reference model plus a shadow of the register file contents.
module tb_regfile_write_ctrl;

  localparam int          NREG = 32;
  localparam int          AW   = 5;
  localparam int          DW   = 32;
  localparam logic [31:0] IV   = 32'hA5A5_0F0F;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_valid, dbg_valid, scrub_req;
  logic [AW-1:0] core_wa, dbg_wa;
  logic [DW-1:0] core_wd, dbg_wd;
  logic          core_ready, dbg_ready;
  logic          rf_we, init_done;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;

  always #5 clk = ~clk;

  regfile_write_ctrl #(
    .NREG     (NREG),
    .AW       (AW),
    .DW       (DW),
    .INIT_VAL (IV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_valid (core_valid),
    .core_wa    (core_wa),
    .core_wd    (core_wd),
    .core_ready (core_ready),
    .dbg_valid  (dbg_valid),
    .dbg_wa     (dbg_wa),
    .dbg_wd     (dbg_wd),
    .dbg_ready  (dbg_ready),
    .scrub_req  (scrub_req),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .init_done  (init_done)
  );

  // register file fed by the DUT write port
  logic [DW-1:0] rf [NREG];
  always @(posedge clk) if (rf_we) rf[rf_wa] <= rf_wd;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  // reference model: scrub progress, last winner, expected port values
  bit            m_run;
  int            m_t;
  bit            m_last_dbg;
  logic          e_we;
  logic [AW-1:0] e_wa;
  logic [DW-1:0] e_wd;
  logic [DW-1:0] sh [NREG];
  bit            shv [NREG];
  int            tgt = -1;

  task automatic model_reset();
    m_run      = 1'b0;
    m_t        = 0;
    m_last_dbg = 1'b1;
    e_we       = 1'b0;
    e_wa       = '0;
    e_wd       = '0;
  endtask

  task automatic chk_rd(input int a);
    if (a >= 0 && a < NREG && shv[a])
      check($sformatf("rd_x%0d", a), {32'h0, rf[a]}, {32'h0, sh[a]});
  endtask

  task automatic step(input bit cv, input logic [AW-1:0] cwa,
                      input logic [DW-1:0] cwd, input bit dv,
                      input logic [AW-1:0] dwa, input logic [DW-1:0] dwd,
                      input bit sr);
    bit er_c, er_d;
    core_valid = cv; core_wa = cwa; core_wd = cwd;
    dbg_valid  = dv; dbg_wa  = dwa; dbg_wd  = dwd;
    scrub_req  = sr;
    #1;
    er_c = 1'b0;
    er_d = 1'b0;
    if (m_run && !sr) begin
      if (cv && dv) begin
        er_c = m_last_dbg;
        er_d = !m_last_dbg;
      end else begin
        er_c = cv;
        er_d = dv;
      end
    end
    check("core_ready", 64'(core_ready), 64'(er_c));
    check("dbg_ready",  64'(dbg_ready),  64'(er_d));
    check("rf_we",      64'(rf_we),      64'(e_we));
    check("rf_wa",      64'(rf_wa),      64'(e_wa));
    check("rf_wd",      64'(rf_wd),      64'(e_wd));
    check("init_done",  64'(init_done),  64'(m_run));
    chk_rd(int'($urandom_range(0, NREG - 1)));
    chk_rd(tgt);
    @(posedge clk);
    if (rst_n) begin
      if (e_we) begin
        sh[e_wa]  = e_wd;
        shv[e_wa] = 1'b1;
      end
      if (!m_run) begin
        m_t++;
        if (m_t <= NREG) begin
          e_we = 1'b1;
          e_wa = AW'(m_t - 1);
          e_wd = (m_t == 1) ? '0 : IV;
        end else begin
          m_run = 1'b1;
          e_we  = 1'b0;
        end
      end else if (sr) begin
        m_run = 1'b0;
        m_t   = 0;
        e_we  = 1'b0;
      end else if (er_c || er_d) begin
        e_wa       = er_c ? cwa : dwa;
        e_wd       = er_c ? cwd : dwd;
        e_we       = (e_wa != '0);
        m_last_dbg = er_d;
      end else begin
        e_we = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    core_valid = 0; core_wa = '0; core_wd = '0;
    dbg_valid  = 0; dbg_wa  = '0; dbg_wd  = '0;
    scrub_req  = 0;
    model_reset();
    repeat (2) @(negedge clk);
    step(1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 0);
    rst_n = 1'b1;

    // full scrub then one idle RUN cycle
    idle(NREG + 2);

    // single core write, read back
    tgt = 5;
    step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 0);
    idle(2);

    // sustained tie: alternating winners
    for (int i = 0; i < 4; i++)
      step(1, 5'd1, 32'h1111_0000 + i, 1, 5'd2, 32'h2222_0000 + i, 0);
    idle(2);

    // debug write to x0 is accepted but suppressed
    tgt = 0;
    step(0, '0, '0, 1, 5'd0, 32'h1234, 0);
    idle(2);

    // scrub request beats a core request
    step(1, 5'd7, 32'h7777, 0, '0, '0, 1);
    idle(NREG + 3);

    // reset in the middle of a scrub
    step(0, '0, '0, 0, '0, '0, 1);
    idle(11);
    rst_n = 1'b0;
    model_reset();
    step(0, '0, '0, 0, '0, '0, 0);
    rst_n = 1'b1;
    idle(NREG + 2);

    // random traffic with occasional scrub and reset
    tgt = -1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step(1, '0, '0, 1, '0, '0, 0);
        rst_n = 1'b1;
      end else begin
        step(1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)),
             DW'($urandom),
             1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)),
             DW'($urandom),
             $urandom_range(0, 59) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
